// File: rtl/duty_scan_pkg.sv
// Shared definitions for the duty-cycle scan scheduler: FSM state encoding,
// settle length and a constant-width helper.
package duty_scan_pkg;

  // State encoding kept as plain constants so older tools and netlists can
  // match the numeric codes.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_MEASURE = 3'd3;
  localparam state_t ST_STORE   = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Synchronizer fill time whose output is discarded before measuring.
  localparam int SETTLE_CYCLES = 2;

  // Bits needed to index 'value' items, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/duty_window_counter.sv
// Two-flop synchronizer plus a window down-counter and a high-cycle counter
// for one selected ring-oscillator input.
module duty_window_counter
  import duty_scan_pkg::*;
#(
  parameter int VAL_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [VAL_W-1:0] win_len,
  input  logic             sig,
  output logic             win_done,
  output logic [VAL_W-1:0] count
);

  logic [1:0]       sync_q, sync_d;
  logic [VAL_W-1:0] rem_q, rem_d;
  logic [VAL_W-1:0] count_q, count_d;

  // Next-state for synchronizer, remaining window and high count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sync_d  = clear ? 2'b00 : {sync_q[0], sig};
    rem_d   = rem_q;
    count_d = count_q;
    if (clear) begin
      // A zero-length window still measures one cycle.
      rem_d   = (win_len == '0) ? '0 : win_len - VAL_W'(1);
      count_d = '0;
    end else if (run) begin
      if (sync_q[1]) count_d = count_q + VAL_W'(1);
      if (rem_q != '0) rem_d = rem_q - VAL_W'(1);
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      sync_q  <= '0;
      rem_q   <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      rem_q   <= rem_d;
      count_q <= count_d;
    end
  end

  assign win_done = run && (rem_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/duty_scan_scheduler.sv
// Scans enabled ring-oscillator channels one at a time, measuring how many
// clock cycles each synchronized input is high within a window, and stores
// the results in a per-channel file.
// Optional: define DUTY_SCAN_CONTINUOUS_EN to let start held in DONE begin a
// new scan immediately instead of returning to IDLE.
module duty_scan_scheduler
  import duty_scan_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int VAL_W = 17,
  localparam int CH_W = clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [VAL_W-1:0] window_len,
  input  logic [N_CH-1:0]  ring_in,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [CH_W-1:0]  res_ch,
  output logic [VAL_W-1:0] res_value,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [VAL_W-1:0] rd_value
);

  state_t           state_q, state_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  visited_q, visited_d;
  logic [VAL_W-1:0] wlen_q, wlen_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [1:0]       settle_q, settle_d;
  logic [VAL_W-1:0] file_q [N_CH];
  logic [VAL_W-1:0] file_d [N_CH];

  logic             found;
  logic [CH_W-1:0]  next_ch;
  logic [N_CH-1:0]  pending;
  logic             cnt_clear, cnt_run, win_done;
  logic [VAL_W-1:0] count;

  duty_window_counter #(.VAL_W(VAL_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .run      (cnt_run),
    .win_len  (wlen_q),
    .sig      (ring_in[ch_q]),
    .win_done (win_done),
    .count    (count)
  );

  // Lowest-index enabled channel not yet measured in this scan.
  always_comb begin
    pending = mask_q & ~visited_q;
    found   = 1'b0;
    next_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

  // Scan sequencing: select, settle, measure, store, repeat until done.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    visited_d = visited_q;
    wlen_d    = wlen_q;
    ch_d      = ch_q;
    settle_d  = settle_q;
    file_d    = file_q;
    cnt_clear = 1'b0;
    cnt_run   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d    = ch_mask;
          wlen_d    = window_len;
          visited_d = '0;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        cnt_clear = 1'b1;
        if (found) begin
          ch_d     = next_ch;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 2'(SETTLE_CYCLES - 1)) state_d = ST_MEASURE;
        else settle_d = settle_q + 2'd1;
      end
      ST_MEASURE: begin
        cnt_run = 1'b1;
        if (win_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        file_d[ch_q]    = count;
        visited_d[ch_q] = 1'b1;
        state_d         = ST_SELECT;
      end
      ST_DONE: begin
`ifdef DUTY_SCAN_CONTINUOUS_EN
        if (start) begin
          mask_d    = ch_mask;
          wlen_d    = window_len;
          visited_d = '0;
          state_d   = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result-file registers; reset overrides any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      visited_q <= '0;
      wlen_q    <= '0;
      ch_q      <= '0;
      settle_q  <= '0;
      // NOTE: the result file is small flop storage and must read back 0 after reset, so it is reset.
      for (int i = 0; i < N_CH; i++) file_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      visited_q <= visited_d;
      wlen_q    <= wlen_d;
      ch_q      <= ch_d;
      settle_q  <= settle_d;
      for (int i = 0; i < N_CH; i++) file_q[i] <= file_d[i];
    end
  end

  // Outputs are forced quiet while reset is asserted, before the state flops clear.
  assign busy      = !reset && (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = !reset && (state_q == ST_DONE);
  assign res_valid = !reset && (state_q == ST_STORE);
  assign res_ch    = res_valid ? ch_q : '0;
  assign res_value = res_valid ? count : '0;
  assign rd_value  = reset ? '0 : file_q[rd_ch];

endmodule

// File: tb/tb_duty_scan_scheduler.sv
// Self-checking bench for duty_scan_scheduler: a scoreboard of expected
// results is filled when a scan is started and drained on res_valid.
module tb_duty_scan_scheduler;

  localparam int N_CH  = 4;
  localparam int VAL_W = 17;
  localparam int CH_W  = 2;

  typedef struct {
    int ch;
    int lo;
    int hi;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N_CH-1:0]  ch_mask;
  logic [VAL_W-1:0] window_len;
  logic [N_CH-1:0]  ring_in;
  logic             busy, done, res_valid;
  logic [CH_W-1:0]  res_ch;
  logic [VAL_W-1:0] res_value;
  logic [CH_W-1:0]  rd_ch;
  logic [VAL_W-1:0] rd_value;

  logic [N_CH-1:0]  ring_static;
  logic             sq_en;
  logic             sq_wave = 1'b0;
  int               sq_cnt = 0;
  int               cyc = 0;
  int               t_start;
  int               checks = 0;
  int               failures = 0;
  exp_t             sb_q[$];
  exp_t             e_mon;

  duty_scan_scheduler #(.N_CH(N_CH), .VAL_W(VAL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ch_mask    (ch_mask),
    .window_len (window_len),
    .ring_in    (ring_in),
    .busy       (busy),
    .done       (done),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_value  (res_value),
    .rd_ch      (rd_ch),
    .rd_value   (rd_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 50% square wave of period 10 cycles for ring_in[1].
  always @(posedge clk) begin
    if (sq_cnt == 4) begin
      sq_cnt  <= 0;
      sq_wave <= ~sq_wave;
    end else begin
      sq_cnt <= sq_cnt + 1;
    end
  end

  assign ring_in = ring_static | {2'b00, sq_en & sq_wave, 1'b0};

  // Scoreboard drain: every res_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && res_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got ch=%0d value=%0d, expected no result", res_ch, res_value);
      end else begin
        e_mon = sb_q.pop_front();
        if (res_ch !== CH_W'(e_mon.ch) || int'(res_value) < e_mon.lo || int'(res_value) > e_mon.hi) begin
          failures++;
          $display("FAIL result got ch=%0d value=%0d, expected ch=%0d value %0d..%0d",
                   res_ch, res_value, e_mon.ch, e_mon.lo, e_mon.hi);
        end
      end
    end
  end

  task automatic start_scan(input logic [N_CH-1:0] m, input int wl);
    @(posedge clk); #1;
    start      = 1'b1;
    ch_mask    = m;
    window_len = VAL_W'(wl);
    t_start    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; checks the latency from start and that all results arrived.
  task automatic wait_done_check(input string name, input int exp_lat);
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t_start;
        break;
      end
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got %0d, expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_results got %0d pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_rd(input string name, input int ch, input int lo, input int hi);
    rd_ch = CH_W'(ch);
    #1;
    checks++;
    if (int'(rd_value) < lo || int'(rd_value) > hi) begin
      failures++;
      $display("FAIL %s rd_ch=%0d got %0d, expected %0d..%0d", name, ch, rd_value, lo, hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || res_ch !== '0 || res_value !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b valid=%b ch=%0d val=%0d, expected all 0",
               busy, done, res_valid, res_ch, res_value);
    end
    for (int i = 0; i < N_CH; i++) check_rd("reset_rd", i, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_reset got busy=%b done=%b valid=%b, expected 0 0 0", busy, done, res_valid);
    end
  endtask

  task automatic test_single_high();
    ring_static = 4'b0001;
    sb_q.push_back('{ch: 0, lo: 100, hi: 100});
    start_scan(4'b0001, 100);
    wait_done_check("single_high", 106);
    @(negedge clk);
    check_rd("single_high_rd", 0, 100, 100);
  endtask

  task automatic test_single_low();
    ring_static = 4'b0000;
    sb_q.push_back('{ch: 0, lo: 0, hi: 0});
    start_scan(4'b0001, 100);
    wait_done_check("single_low", 106);
  endtask

  task automatic test_two_channels();
    ring_static = 4'b1000;
    sq_en       = 1'b1;
    sb_q.push_back('{ch: 1, lo: 49, hi: 51});
    sb_q.push_back('{ch: 3, lo: 100, hi: 100});
    start_scan(4'b1010, 100);
    // A start while busy must be ignored; the latency check catches a restart.
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL two_ch_busy got %b, expected 1", busy);
    end
    start   = 1'b1;
    ch_mask = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done_check("two_ch", 210);
    sq_en = 1'b0;
    @(negedge clk);
    check_rd("two_ch_rd", 3, 100, 100);
  endtask

  task automatic test_zero_mask();
    start_scan(4'b0000, 100);
    wait_done_check("zero_mask", 2);
  endtask

  task automatic test_zero_window();
    ring_static = 4'b0001;
    sb_q.push_back('{ch: 0, lo: 1, hi: 1});
    start_scan(4'b0001, 0);
    wait_done_check("zero_window", 7);
    @(negedge clk);
    check_rd("kept_ch3", 3, 100, 100);
    check_rd("kept_ch1", 1, 49, 51);
    check_rd("zero_window_rd", 0, 1, 1);
  endtask

  task automatic test_reset_mid_measure();
    bit saw_busy;
    ring_static = 4'b0001;
    start_scan(4'b0001, 100);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_during got busy=%b valid=%b, expected 0 0", busy, res_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after got busy=%b valid=%b done=%b, expected 0 0 0", busy, res_valid, done);
    end
    for (int i = 0; i < N_CH; i++) check_rd("mid_reset_rd", i, 0, 0);
    saw_busy = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin
      failures++;
      $display("FAIL mid_reset_idle got activity after reset, expected idle");
    end
  endtask

`ifdef DUTY_SCAN_CONTINUOUS_EN
  task automatic test_continuous();
    ring_static = 4'b0001;
    sb_q.push_back('{ch: 0, lo: 10, hi: 10});
    sb_q.push_back('{ch: 0, lo: 10, hi: 10});
    @(posedge clk); #1;
    start      = 1'b1;
    ch_mask    = 4'b0001;
    window_len = VAL_W'(10);
    t_start    = cyc;
    wait_done_check_first();
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_reselect got busy=%b, expected 1", busy);
    end
    t_start = t_start + 16;
    wait_done_check("cont_second", 16);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_stop got busy=%b, expected 0", busy);
    end
  endtask

  // First done of a continuous run: latency 1+2+10+1+2 = 16 from start.
  task automatic wait_done_check_first();
    int lat;
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t_start;
        break;
      end
    end
    checks++;
    if (!seen || lat != 16) begin
      failures++;
      $display("FAIL cont_first_latency got %0d, expected 16", lat);
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    ch_mask     = '0;
    window_len  = '0;
    ring_static = '0;
    sq_en       = 1'b0;
    rd_ch       = '0;
    test_reset();
    test_single_high();
    test_single_low();
    test_two_channels();
    test_zero_mask();
    test_zero_window();
    test_reset_mid_measure();
`ifdef DUTY_SCAN_CONTINUOUS_EN
    test_continuous();
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
